// File: rtl/vga_fb_rect_fill_80x60.sv
// Rectangle-fill engine for the 80x60 framebuffer write port: one pixel per clock, row-major.
// Define FB_FILL_CLIP_EN to clamp out-of-range corners instead of rejecting the request.
module vga_fb_rect_fill_80x60 (
  input  logic        CLK_50MHz,
  input  logic        RST,
  input  logic        START,
  input  logic        ABORT,
  input  logic [6:0]  X0,
  input  logic [6:0]  X1,
  input  logic [5:0]  Y0,
  input  logic [5:0]  Y1,
  input  logic [7:0]  COLOR,
  output logic [12:0] WA,
  output logic [7:0]  WD,
  output logic        WE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  typedef enum logic [1:0] {IDLE, FILL, FIN} state_t;

  state_t      state_q, state_d;
  logic [6:0]  x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
  logic [5:0]  y_q, y_d, ymax_q, ymax_d;
  logic [12:0] wa_q, wa_d;
  logic [7:0]  wd_q, wd_d;
  logic        we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [6:0]  x0c, x1c, xlo, xhi;
  logic [5:0]  y0c, y1c, ylo, yhi;
  logic        oor;

  always_comb begin
`ifdef FB_FILL_CLIP_EN
    x0c = (X0 > 7'd79) ? 7'd79 : X0;
    x1c = (X1 > 7'd79) ? 7'd79 : X1;
    y0c = (Y0 > 6'd59) ? 6'd59 : Y0;
    y1c = (Y1 > 6'd59) ? 6'd59 : Y1;
    oor = 1'b0;
`else
    x0c = X0;
    x1c = X1;
    y0c = Y0;
    y1c = Y1;
    oor = (X0 > 7'd79) || (X1 > 7'd79) || (Y0 > 6'd59) || (Y1 > 6'd59);
`endif
    xlo = (x0c < x1c) ? x0c : x1c;
    xhi = (x0c < x1c) ? x1c : x0c;
    ylo = (y0c < y1c) ? y0c : y1c;
    yhi = (y0c < y1c) ? y1c : y0c;
  end

  // WA/WE are computed one cycle ahead so the registered outputs show the current pixel.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymax_d  = ymax_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          if (oor) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = FILL;
            xmin_d  = xlo;
            xmax_d  = xhi;
            ymax_d  = yhi;
            x_d     = xlo;
            y_d     = ylo;
            wa_d    = {ylo, xlo};
            wd_d    = COLOR;
            we_d    = 1'b1;
            err_d   = 1'b0;
          end
        end
      end
      FILL: begin
        if (ABORT) begin
          state_d = IDLE;
        end else if (x_q != xmax_q) begin
          x_d  = x_q + 7'd1;
          wa_d = {y_q, x_q + 7'd1};
          we_d = 1'b1;
        end else if (y_q != ymax_q) begin
          x_d  = xmin_q;
          y_d  = y_q + 6'd1;
          wa_d = {y_q + 6'd1, xmin_q};
          we_d = 1'b1;
        end else begin
          state_d = FIN;
          done_d  = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK_50MHz or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymax_q  <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymax_q  <= ymax_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign WA   = wa_q;
  assign WD   = wd_q;
  assign WE   = we_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_vga_fb_rect_fill_80x60.sv
// Directed bench for vga_fb_rect_fill_80x60; inputs change and outputs are sampled on the falling edge.
// Define FB_FILL_CLIP_EN here too when building the clipping variant.
module tb_vga_fb_rect_fill_80x60;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [6:0]  x0 = '0, x1 = '0;
  logic [5:0]  y0 = '0, y1 = '0;
  logic [7:0]  color = '0;
  logic [12:0] wa;
  logic [7:0]  wd;
  logic        we, busy, done, err;

  int total = 0;
  int bad = 0;

  vga_fb_rect_fill_80x60 dut (
    .CLK_50MHz(clk), .RST(rst), .START(start), .ABORT(abort),
    .X0(x0), .X1(x1), .Y0(y0), .Y1(y1), .COLOR(color),
    .WA(wa), .WD(wd), .WE(we), .BUSY(busy), .DONE(done), .ERR(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic checkWrite(input string tag, input logic [12:0] addr, input logic [7:0] data);
    checkOutput({tag, ".we"}, 32'(we), 32'd1);
    checkOutput({tag, ".wa"}, 32'(wa), 32'(addr));
    checkOutput({tag, ".wd"}, 32'(wd), 32'(data));
    checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
    checkOutput({tag, ".done"}, 32'(done), 32'd0);
  endtask

  task automatic checkFin(input string tag);
    checkOutput({tag, ".we"}, 32'(we), 32'd0);
    checkOutput({tag, ".done"}, 32'(done), 32'd1);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".we"}, 32'(we), 32'd0);
    checkOutput({tag, ".done"}, 32'(done), 32'd0);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  // Loads corners and pulses START across one rising edge; returns at the negedge of cycle n+1.
  task automatic applyStimulus(input logic [6:0] ax0, input logic [6:0] ax1,
                               input logic [5:0] ay0, input logic [5:0] ay1,
                               input logic [7:0] acol);
    x0 = ax0; x1 = ax1; y0 = ay0; y1 = ay1; color = acol;
    start = 1'b1;
    nextCycle();
    start = 1'b0;
  endtask

  initial begin
    logic [12:0] basicAddr [6];
    basicAddr[0] = 13'h082; basicAddr[1] = 13'h083; basicAddr[2] = 13'h084;
    basicAddr[3] = 13'h102; basicAddr[4] = 13'h103; basicAddr[5] = 13'h104;

    #1 rst = 1'b1;
    #2;
    checkOutput("rst.wa", 32'(wa), 32'd0);
    checkOutput("rst.wd", 32'(wd), 32'd0);
    checkOutput("rst.err", 32'(err), 32'd0);
    checkIdle("rst");
    nextCycle();
    rst = 1'b0;
    nextCycle();

    // Basic fill: 3x2 pixels in red
    applyStimulus(7'd2, 7'd4, 6'd1, 6'd2, 8'hE0);
    for (int i = 0; i < 6; i++) begin
      checkWrite($sformatf("basic%0d", i), basicAddr[i], 8'hE0);
      nextCycle();
    end
    checkFin("basic.fin");
    nextCycle();
    checkIdle("basic.idle");
    nextCycle();

    // Swapped corners at the bottom-right edge
    applyStimulus(7'd79, 7'd78, 6'd59, 6'd59, 8'h03);
    checkWrite("swap0", 13'h1DCE, 8'h03);
    nextCycle();
    checkWrite("swap1", 13'h1DCF, 8'h03);
    nextCycle();
    checkFin("swap.fin");
    nextCycle();
    checkIdle("swap.idle");

    // Single pixel with START held through BUSY; colour change must not leak into the first fill
    x0 = 7'd0; x1 = 7'd0; y0 = 6'd0; y1 = 6'd0; color = 8'h1C;
    start = 1'b1;
    nextCycle();
    color = 8'h55;
    checkWrite("single", 13'h000, 8'h1C);
    nextCycle();
    checkFin("single.fin");
    nextCycle();
    checkIdle("single.idle");
    nextCycle();
    start = 1'b0;
    checkWrite("held", 13'h000, 8'h55);
    nextCycle();
    checkFin("held.fin");
    nextCycle();
    checkIdle("held.idle");

    // Full screen, abort on the 100th write (pixel 99 = row 1, col 19)
    applyStimulus(7'd0, 7'd79, 6'd0, 6'd59, 8'hFF);
    checkWrite("full.first", 13'h000, 8'hFF);
    for (int i = 1; i < 100; i++) nextCycle();
    checkWrite("full.w100", 13'h093, 8'hFF);
    abort = 1'b1;
    nextCycle();
    abort = 1'b0;
    checkIdle("abort");
    nextCycle();
    checkIdle("abort.after");
    checkOutput("abort.err", 32'(err), 32'd0);

    // Full screen again, asynchronous reset between edges
    applyStimulus(7'd0, 7'd79, 6'd0, 6'd59, 8'h0F);
    for (int i = 1; i < 50; i++) nextCycle();
    checkWrite("rstmid.w50", 13'h031, 8'h0F);
    #2 rst = 1'b1;
    #1;
    checkIdle("rstmid");
    checkOutput("rstmid.wa", 32'(wa), 32'd0);
    checkOutput("rstmid.wd", 32'(wd), 32'd0);
    nextCycle();
    rst = 1'b0;
    nextCycle();
    checkIdle("rstmid.after");

    // Out-of-range corners X0=85, Y1=70
    applyStimulus(7'd85, 7'd3, 6'd2, 6'd70, 8'hAA);
`ifdef FB_FILL_CLIP_EN
    checkWrite("clip0", 13'h103, 8'hAA);
    checkOutput("clip.err", 32'(err), 32'd0);
    nextCycle();
    checkWrite("clip1", 13'h104, 8'hAA);
    abort = 1'b1;
    nextCycle();
    abort = 1'b0;
    checkIdle("clip.abort");
`else
    checkOutput("oor.we", 32'(we), 32'd0);
    checkOutput("oor.err", 32'(err), 32'd1);
    checkOutput("oor.done", 32'(done), 32'd1);
    checkOutput("oor.busy", 32'(busy), 32'd0);
    nextCycle();
    checkIdle("oor.after");
    checkOutput("oor.sticky", 32'(err), 32'd1);
`endif

    // An accepted START clears ERR
    applyStimulus(7'd5, 7'd5, 6'd3, 6'd3, 8'h42);
    checkWrite("clr", 13'h185, 8'h42);
    checkOutput("clr.err", 32'(err), 32'd0);
    nextCycle();
    checkFin("clr.fin");
    nextCycle();
    checkIdle("clr.idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_rect_fill_80x60.md
# vga_fb_rect_fill_80x60

Hardware rectangle-fill engine that writes into the 80x60 VGA framebuffer's write port (WA/WD/WE). The OTTER MCU loads corner coordinates and an 8-bit RRRGGGBB colour and pulses START. The engine then emits one framebuffer write per clock until the rectangle is painted, so the CPU does not have to loop over every pixel. It sits between the MCU's memory-mapped I/O and the framebuffer driver's write interface. It is the writer side of the framebuffer that the VGA scan-out reads.

## Interface
- COLS, 80, framebuffer width in pixels; column field is 7 bits
- ROWS, 60, framebuffer height in pixels; row field is 6 bits
- CLK_50MHz  in  1  system clock, same domain as the framebuffer write port
- RST  in  1  reset, asynchronous, active-high
- START  in  1  request a fill; sampled only in IDLE
- ABORT  in  1  cancel an active fill
- X0, X1  in  7  corner columns (inclusive), any order
- Y0, Y1  in  6  corner rows (inclusive), any order
- COLOR  in  8  fill colour, RRRGGGBB
- WA  out  13  framebuffer write address {row[5:0], col[6:0]}
- WD  out  8  write data (latched COLOR)
- WE  out  1  write enable, one pixel per cycle
- BUSY  out  1  engine is not in IDLE
- DONE  out  1  one-cycle pulse at completion or error
- ERR  out  1  last request was rejected; sticky until the next accepted START

## Operation
- States: IDLE, FILL, FIN.
- IDLE to FILL, on START=1:
  - Latch xmin=min(X0,X1), xmax=max(X0,X1), ymin=min(Y0,Y1), ymax=max(Y0,Y1) and COLOR.
  - Set cursor (x,y)=(xmin,ymin) and clear ERR.
- FILL, each cycle:
  - Drive WE=1, WA={y,x}, WD=COLOR.
  - If x≠xmax: x++.
  - If x=xmax and y≠ymax: x=xmin, y++.
  - If x=xmax and y=ymax: go to FIN.
- FIN: DONE=1 for one cycle, then return to IDLE.
- Raster order is row-major, left to right, top to bottom. Pixel count is exactly (xmax−xmin+1)(ymax−ymin+1).
- A single-pixel rectangle (X0=X1, Y0=Y1) gives exactly one write.
- Cursor arithmetic is unsigned and never wraps past xmax/ymax. Address is a bit concatenation; there is no multiply.
- START while BUSY is ignored, including during the FIN cycle.
- ABORT in FILL or FIN: return to IDLE next cycle, WE=0, no DONE pulse, ERR unchanged. ABORT in IDLE has no effect. If START and ABORT are both high in IDLE, START wins.
- Out-of-range coordinates (X>79 or Y>59) are handled as described under Configuration.
- RST, at any time including mid-fill:
  - State goes to IDLE immediately.
  - WE, BUSY, DONE and ERR go to 0; WA and WD go to 0.
  - Pixels already written stay written. The partial fill is not resumed.

## Timing
- All outputs are registered.
- START sampled high at edge n:
  - BUSY=1 from cycle n+1.
  - First WE=1 in cycle n+1, carrying pixel (xmin,ymin).
- For N pixels:
  - WE is high in cycles n+1 … n+N with no gaps.
  - DONE=1 in cycle n+N+1 (FIN), with BUSY still high.
  - BUSY=0 in cycle n+N+2. A new START is accepted at that edge.
- Throughput: 1 pixel/cycle. A full screen (4800 pixels) takes 4802 cycles from START to IDLE.
- WE is never high in IDLE or FIN.

## Configuration
- FB_FILL_CLIP_EN defined:
  - Out-of-range coordinates are clamped (X to 79, Y to 59) before min/max.
  - The fill proceeds normally and ERR stays 0.
- FB_FILL_CLIP_EN undefined:
  - START with any out-of-range coordinate stays in IDLE and performs no writes.
  - ERR=1 and DONE=1 in cycle n+1; BUSY stays 0.

## Test plan
- Basic fill:
  - Stimulus: X0=2, X1=4, Y0=1, Y1=2, COLOR=0xE0, START.
  - Response: 6 writes at WA 0x082, 0x083, 0x084, 0x102, 0x103, 0x104, all with WD=0xE0. DONE in cycle n+7; BUSY low in cycle n+8.
- Swapped corners:
  - Stimulus: X0=79, X1=78, Y0=59, Y1=59.
  - Response: writes at 0x1DCE then 0x1DCF; DONE one cycle later.
- Single pixel and back-to-back:
  - Stimulus: (0,0)-(0,0) colour 0x1C, then a second START held during BUSY.
  - Response: exactly one write at WA=0, WD=0x1C. The held START is accepted only after BUSY falls.
- Abort and reset:
  - Stimulus: full screen fill with ABORT at write 100.
  - Response: WE=0 next cycle, no DONE, BUSY=0.
  - Stimulus: repeat with RST asserted mid-fill.
  - Response: all outputs 0 asynchronously.
- Out of range, X0=85, Y1=70:
  - Without FB_FILL_CLIP_EN: zero writes, ERR=1 and DONE=1 at n+1.
  - With FB_FILL_CLIP_EN: the fill is clamped to columns ≤79 and rows ≤59, and ERR=0.
